axi_burst_read_dma: RTL and testbench



---
 rtl/axi_burst_read_dma_if.sv | 31 +++
 rtl/axi_burst_read_dma.sv | 117 +++++++++++
 tb/tb_axi_burst_read_dma.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_read_dma_if.sv
// axi_burst_read_dma_if: command, AXI4 AR/R, output stream and status bundle; master = DMA, slave = DDR/host side
interface axi_burst_read_dma_if #(parameter int DATA_W = 512);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [63:0]       cmd_addr;
  logic [31:0]       cmd_beats;
  logic [63:0]       ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    input  cmd_valid, cmd_addr, cmd_beats, ARREADY, RDATA, RLAST, RRESP, RVALID, out_ready,
    output cmd_ready, ARADDR, ARLEN, ARVALID, RREADY, out_data, out_valid, out_last, busy, done, err
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_beats, ARREADY, RDATA, RLAST, RRESP, RVALID, out_ready,
    input  cmd_ready, ARADDR, ARLEN, ARVALID, RREADY, out_data, out_valid, out_last, busy, done, err
  );
endinterface

// File: rtl/axi_burst_read_dma.sv
// axi_burst_read_dma: AXI4 read master splitting (addr, beats) commands into 4KB-safe bursts; ports clk, rst, bus (cmd in, AR/R to DDR, FIFO-fed out stream, busy/done/err)
module axi_burst_read_dma #(
  parameter int DATA_W     = 512,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input logic clk,
  input logic rst,
  axi_burst_read_dma_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t            state;
  logic [63:0]       cur_addr;
  logic [31:0]       remaining;
  logic [8:0]        blen;
  logic [8:0]        beat_cnt;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              burst_end;
  logic              last_tag;
  logic              drained;
  logic [31:0]       page_beats;
  logic [31:0]       len_w;
  logic [31:0]       free;
  assign bus.cmd_ready = !rst && state == IDLE;
  always_comb begin
    push = state == DATA && bus.RVALID && bus.RREADY;
    pop = bus.out_valid && bus.out_ready;
    bus.out_valid = count != 0;
    {bus.out_last, bus.out_data} = (count != 0) ? mem[rptr] : '0;
    page_beats = 32'((13'h1000 - {1'b0, cur_addr[11:0]}) >> 6);
    len_w = remaining < 32'(MAX_BURST) ? remaining : 32'(MAX_BURST);
    len_w = page_beats < len_w ? page_beats : len_w;
    free = 32'(FIFO_DEPTH) - 32'(count);
    burst_end = push && (bus.RLAST || beat_cnt + 9'd1 == blen);
    last_tag = burst_end && remaining == {23'b0, blen};
    drained = count == 0 || (count == 1 && pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {last_tag, bus.RDATA};
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      blen <= '0;
      beat_cnt <= '0;
      bus.ARADDR <= '0;
      bus.ARLEN <= '0;
      bus.ARVALID <= 1'b0;
      bus.RREADY <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          cur_addr <= bus.cmd_addr;
          remaining <= bus.cmd_beats;
          bus.err <= bus.cmd_addr[5:0] != 6'd0;
          if (bus.cmd_addr[5:0] != 6'd0 || bus.cmd_beats == 32'd0) bus.done <= 1'b1;
          else begin
            bus.busy <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: if (!bus.ARVALID) begin
          if (free >= len_w) begin
            bus.ARVALID <= 1'b1;
            bus.ARADDR <= cur_addr;
            bus.ARLEN <= 8'(len_w - 32'd1);
            blen <= 9'(len_w);
          end
        end else if (bus.ARREADY) begin
          bus.ARVALID <= 1'b0;
          bus.RREADY <= 1'b1;
          beat_cnt <= '0;
          state <= DATA;
        end
        DATA: if (push) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (bus.RRESP != 2'd0 || bus.RLAST != (beat_cnt + 9'd1 == blen)) bus.err <= 1'b1;
          if (burst_end) begin
            bus.RREADY <= 1'b0;
            cur_addr <= cur_addr + {49'b0, blen, 6'b0};
            remaining <= remaining - {23'b0, blen};
            state <= remaining == {23'b0, blen} ? DRAIN : ADDR;
          end
        end
        DRAIN: if (drained) begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && count == (AW+1)'(FIFO_DEPTH)));
endmodule

// File: tb/tb_axi_burst_read_dma.sv
// tb_axi_burst_read_dma: directed bench with DDR responder and output-stream monitor
module tb_axi_burst_read_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  axi_burst_read_dma_if bus ();
  axi_burst_read_dma dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int ar_n = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int mon_total = 0;
  logic [63:0] mon_addr = '0;
  logic [63:0] ar_addr [8];
  logic [7:0] ar_len [8];
  bit inj = 1'b0;
  bit r_act = 1'b0;
  int r_i = 0;
  int r_len = 0;
  logic [63:0] r_addr = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.ARREADY = 1'b1;
    bus.RVALID = 1'b0;
    bus.RLAST = 1'b0;
    bus.RRESP = 2'd0;
    bus.RDATA = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        r_act = 1'b0;
        bus.RVALID = 1'b0;
        bus.RLAST = 1'b0;
      end else begin
        if (r_act) begin
          bus.RVALID = 1'b1;
          bus.RDATA = {8{r_addr}};
          bus.RLAST = r_i == r_len;
          bus.RRESP = (inj && r_i == 1) ? 2'd2 : 2'd0;
          if (bus.RREADY) begin
            r_i++;
            r_addr += 64'd64;
            if (r_i > r_len) r_act = 1'b0;
          end
        end else begin
          bus.RVALID = 1'b0;
          bus.RLAST = 1'b0;
          bus.RRESP = 2'd0;
        end
        if (bus.ARVALID && bus.ARREADY) begin
          if (ar_n < 8) begin
            ar_addr[ar_n] = bus.ARADDR;
            ar_len[ar_n] = bus.ARLEN;
          end
          ar_n++;
          r_act = 1'b1;
          r_addr = bus.ARADDR;
          r_i = 0;
          r_len = int'(bus.ARLEN);
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      chk("out_data_lo", bus.out_data[63:0], mon_addr);
      chk("out_data_hi", bus.out_data[511:448], mon_addr);
      chk("out_last", 64'(bus.out_last), 64'(pop_cnt == mon_total - 1));
      mon_addr += 64'd64;
      pop_cnt++;
    end
    if (!rst && bus.done) done_cnt++;
  end
  task automatic send_cmd(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    ar_n = 0;
    pop_cnt = 0;
    done_cnt = 0;
    mon_addr = a;
    mon_total = int'(b);
    chk("cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_beats = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.done; i++) @(negedge clk);
    chk("done_seen", 64'(bus.done), 64'd1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_beats = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_arvalid", 64'(bus.ARVALID), 64'd0);
    chk("rst_araddr", bus.ARADDR, 64'd0);
    chk("rst_arlen", 64'(bus.ARLEN), 64'd0);
    chk("rst_rready", 64'(bus.RREADY), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_status", 64'({bus.busy, bus.done, bus.err}), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(64'h1000, 32'd40);
    wait_done(300);
    @(negedge clk);
    chk("done_pulse_len", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    chk("a_ar_count", 64'(ar_n), 64'd3);
    chk("a_ar0_addr", ar_addr[0], 64'h1000);
    chk("a_ar0_len", 64'(ar_len[0]), 64'd15);
    chk("a_ar1_addr", ar_addr[1], 64'h1400);
    chk("a_ar1_len", 64'(ar_len[1]), 64'd15);
    chk("a_ar2_addr", ar_addr[2], 64'h1800);
    chk("a_ar2_len", 64'(ar_len[2]), 64'd7);
    chk("a_pops", 64'(pop_cnt), 64'd40);
    chk("a_done_cnt", 64'(done_cnt), 64'd1);
    chk("a_err", 64'(bus.err), 64'd0);
    chk("a_busy", 64'(bus.busy), 64'd0);
    send_cmd(64'h1F80, 32'd4);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("s_ar_count", 64'(ar_n), 64'd2);
    chk("s_ar0_addr", ar_addr[0], 64'h1F80);
    chk("s_ar0_len", 64'(ar_len[0]), 64'd1);
    chk("s_ar1_addr", ar_addr[1], 64'h2000);
    chk("s_ar1_len", 64'(ar_len[1]), 64'd1);
    chk("s_pops", 64'(pop_cnt), 64'd4);
    bus.out_ready = 1'b0;
    send_cmd(64'h0, 32'd64);
    repeat (100) @(negedge clk);
    chk("bp_ar_count", 64'(ar_n), 64'd2);
    chk("bp_arvalid", 64'(bus.ARVALID), 64'd0);
    chk("bp_busy", 64'(bus.busy), 64'd1);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    wait_done(500);
    repeat (2) @(negedge clk);
    chk("bp_ar_total", 64'(ar_n), 64'd4);
    chk("bp_ar3_addr", ar_addr[3], 64'hC00);
    chk("bp_pops", 64'(pop_cnt), 64'd64);
    chk("bp_err", 64'(bus.err), 64'd0);
    send_cmd(64'h1008, 32'd4);
    chk("mis_done", 64'(bus.done), 64'd1);
    chk("mis_err", 64'(bus.err), 64'd1);
    chk("mis_arvalid", 64'(bus.ARVALID), 64'd0);
    repeat (3) @(negedge clk);
    chk("mis_ar_count", 64'(ar_n), 64'd0);
    chk("mis_err_sticky", 64'(bus.err), 64'd1);
    chk("mis_done_cnt", 64'(done_cnt), 64'd1);
    send_cmd(64'h2000, 32'd0);
    chk("zero_done", 64'(bus.done), 64'd1);
    chk("zero_err_cleared", 64'(bus.err), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_ar_count", 64'(ar_n), 64'd0);
    chk("zero_pops", 64'(pop_cnt), 64'd0);
    inj = 1'b1;
    send_cmd(64'h3000, 32'd3);
    wait_done(200);
    inj = 1'b0;
    repeat (3) @(negedge clk);
    chk("rresp_err", 64'(bus.err), 64'd1);
    chk("rresp_pops", 64'(pop_cnt), 64'd3);
    chk("rresp_ar_len", 64'(ar_len[0]), 64'd2);
    send_cmd(64'h4000, 32'd1);
    chk("one_err_cleared", 64'(bus.err), 64'd0);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("one_ar_len", 64'(ar_len[0]), 64'd0);
    chk("one_pops", 64'(pop_cnt), 64'd1);
    bus.out_ready = 1'b0;
    send_cmd(64'h5000, 32'd16);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    @(negedge clk);
    chk("mid_rready", 64'(bus.RREADY), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("mr_arvalid", 64'(bus.ARVALID), 64'd0);
    chk("mr_araddr", bus.ARADDR, 64'd0);
    chk("mr_rready", 64'(bus.RREADY), 64'd0);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_last", 64'(bus.out_last), 64'd0);
    chk("mr_out_data", bus.out_data[63:0], 64'd0);
    chk("mr_status", 64'({bus.busy, bus.done, bus.err}), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_cmd(64'h6000, 32'd2);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("pr_ar_addr", ar_addr[0], 64'h6000);
    chk("pr_ar_len", 64'(ar_len[0]), 64'd1);
    chk("pr_pops", 64'(pop_cnt), 64'd2);
    chk("pr_err", 64'(bus.err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
